// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   word_t          32-bit datapath word
//   aluop_t         ALU operation encoding
//   alu_arb_state_t sequencer states of alu_arbiter
//   alu_arb_op_t    operation captured at request handshake
//   alu_arb_rsp_t   result and flags captured from the ALU
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

  typedef struct packed {
    logic   owner;
    aluop_t aluop;
    word_t  porta;
    word_t  portb;
  } alu_arb_op_t;

  typedef struct packed {
    word_t data;
    logic  neg;
    logic  zero;
    logic  overflow;
  } alu_arb_rsp_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//   req[1:0]  request bits
//   prio      requester that wins when both request
//   en        grant enable; gnt is 0 when low
//   gnt[1:0]  one-hot grant (0 when no request or disabled)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = prio ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer for the single shared ALU.
// One operation in flight: accept in IDLE, drive the ALU for one cycle in
// EXEC, hold the registered result in RESP until the owner accepts it.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   req_valid/req_ready[2]      request handshake per requester
//   req_aluop/porta/portb[2]    requested operation and operands
//   alu_aluop/porta/portb       to the ALU (0 outside EXEC)
//   alu_portout, alu_neg/zero/overflow   from the ALU, combinational
//   rsp_valid/rsp_ready[2]      response handshake per requester
//   rsp_data, rsp_neg/zero/overflow      registered result and flags
//   busy                        high whenever not IDLE
//   grant_cnt0/1                per-requester accepted-request counters,
//                               present only when ALU_ARB_PERF_EN is defined
//
// state | meaning
// IDLE  | arbitrating; req_ready to the winner
// EXEC  | ALU driven from the op register; result captured at the edge
// RESP  | rsp_valid to the owner until its rsp_ready
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  aluop_t          req_aluop [NREQ],
  input  word_t           req_porta [NREQ],
  input  word_t           req_portb [NREQ],
  output aluop_t          alu_aluop,
  output word_t           alu_porta,
  output word_t           alu_portb,
  input  word_t           alu_portout,
  input  logic            alu_neg,
  input  logic            alu_zero,
  input  logic            alu_overflow,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output word_t           rsp_data,
  output logic            rsp_neg,
  output logic            rsp_zero,
  output logic            rsp_overflow,
  output logic            busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]     grant_cnt0,
  output logic [31:0]     grant_cnt1
`endif
);

  alu_arb_state_t state_q, state_d;
  logic           prio_q, prio_d;
  alu_arb_op_t    op_q, op_d;
  alu_arb_rsp_t   rsp_q, rsp_d;
  logic [1:0]     gnt;
  logic           winner;

  // gnt is nonzero only in IDLE with a matching req_valid, so it doubles
  // as the request-handshake strobe.
  rr_arb2 u_rr_arb2 (
    .req  (req_valid),
    .prio (prio_q),
    .en   (state_q == IDLE),
    .gnt  (gnt)
  );

  assign winner = gnt[1];

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    op_d      = op_q;
    rsp_d     = rsp_q;
    req_ready = '0;
    rsp_valid = '0;
    alu_aluop = ALU_ADD;
    alu_porta = '0;
    alu_portb = '0;

    case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (gnt != 2'b00) begin
          op_d.owner = winner;
          op_d.aluop = req_aluop[winner];
          op_d.porta = req_porta[winner];
          op_d.portb = req_portb[winner];
          prio_d     = ~winner;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        alu_aluop      = op_q.aluop;
        alu_porta      = op_q.porta;
        alu_portb      = op_q.portb;
        rsp_d.data     = alu_portout;
        rsp_d.neg      = alu_neg;
        rsp_d.zero     = alu_zero;
        rsp_d.overflow = alu_overflow;
        state_d        = RESP;
      end
      RESP: begin
        rsp_valid[op_q.owner] = 1'b1;
        if (rsp_ready[op_q.owner]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      op_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp_data     = rsp_q.data;
  assign rsp_neg      = rsp_q.neg;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.overflow;
  assign busy         = (state_q != IDLE);

`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q + {31'd0, gnt[0]};
    grant_cnt1_d = grant_cnt1_q + {31'd0, gnt[1]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// The bench plays the ALU (combinational reference) and both requesters.
// Counter checks are compiled in when ALU_ARB_PERF_EN is defined.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  aluop_t     req_aluop [2];
  word_t      req_porta [2];
  word_t      req_portb [2];
  aluop_t     alu_aluop;
  word_t      alu_porta, alu_portb, alu_portout;
  logic       alu_neg, alu_zero, alu_overflow;
  word_t      rsp_data;
  logic       rsp_neg, rsp_zero, rsp_overflow, busy;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.NREQ(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_aluop    (req_aluop),
    .req_porta    (req_porta),
    .req_portb    (req_portb),
    .alu_aluop    (alu_aluop),
    .alu_porta    (alu_porta),
    .alu_portb    (alu_portb),
    .alu_portout  (alu_portout),
    .alu_neg      (alu_neg),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_neg      (rsp_neg),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
`ifdef ALU_ARB_PERF_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1)
`endif
  );

  typedef struct packed {
    word_t data;
    logic  neg;
    logic  zero;
    logic  ovf;
  } res_t;

  function automatic res_t alu_fn(aluop_t op, word_t a, word_t b);
    res_t r;
    r.ovf = 1'b0;
    case (op)
      ALU_ADD: begin r.data = a + b; r.ovf = (a[31] == b[31]) && (r.data[31] != a[31]); end
      ALU_SUB: begin r.data = a - b; r.ovf = (a[31] != b[31]) && (r.data[31] != a[31]); end
      ALU_AND: r.data = a & b;
      ALU_OR:  r.data = a | b;
      ALU_XOR: r.data = a ^ b;
      ALU_SLL: r.data = a << b[4:0];
      ALU_SRL: r.data = a >> b[4:0];
      ALU_SLT: r.data = {31'd0, ($signed(a) < $signed(b))};
      default: r.data = '0;
    endcase
    r.neg  = r.data[31];
    r.zero = (r.data == 32'd0);
    return r;
  endfunction

  // Shared ALU model
  res_t alu_res;
  always_comb begin
    alu_res      = alu_fn(alu_aluop, alu_porta, alu_portb);
    alu_portout  = alu_res.data;
    alu_neg      = alu_res.neg;
    alu_zero     = alu_res.zero;
    alu_overflow = alu_res.ovf;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_aluop[i] = ALU_ADD;
      req_porta[i] = '0;
      req_portb[i] = '0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic set_req(input int r, input aluop_t op, input word_t a, input word_t b);
    req_aluop[r] = op;
    req_porta[r] = a;
    req_portb[r] = b;
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic one_op(input int r);
    req_valid = 2'b01 << r;
    set_req(r, ALU_ADD, 32'd1, 32'd2);
    rsp_ready = 2'b11;
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    cyc();
  endtask
`endif

  typedef struct {
    int     r;
    aluop_t op;
    word_t  a;
    word_t  b;
    word_t  d;
    logic   neg;
    logic   zero;
    logic   ovf;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         have_op;
    int         age, m_owner, m_prio, w, g;
    aluop_t     m_op;
    word_t      m_a, m_b;
    res_t       m_res;
    logic [1:0] exp_ready, exp_rv;

    tbl[0] = '{0, ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
    tbl[1] = '{1, ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1, 1'b0, 1'b1};
    tbl[2] = '{0, ALU_SUB, 32'd9,          32'd9,          32'd0,          1'b0, 1'b1, 1'b0};
    tbl[3] = '{1, ALU_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};
    tbl[4] = '{0, ALU_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
    tbl[5] = '{1, ALU_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b1, 1'b0, 1'b0};
    tbl[6] = '{0, ALU_XOR, 32'hA5A5_A5A5,  32'hA5A5_A5A5,  32'd0,          1'b0, 1'b1, 1'b0};
    tbl[7] = '{1, ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
    tbl[8] = '{0, ALU_SLL, 32'd1,          32'd31,         32'h8000_0000,  1'b1, 1'b0, 1'b0};
    tbl[9] = '{1, ALU_OR,  32'h0000_1200,  32'h0000_0034,  32'h0000_1234,  1'b0, 1'b0, 1'b0};

    clear_inputs();
    do_reset();

    // Reset state
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp", {rsp_data, rsp_neg, rsp_zero, rsp_overflow}, 35'd0);
    chk("reset_alu", {alu_aluop, alu_porta, alu_portb} != 0, 1'b0);

    // Single-request vectors: handshake cycle 0, ALU cycle 1, response cycle 2
    for (int e = 0; e < 10; e++) begin
      req_valid = 2'b01 << tbl[e].r;
      set_req(tbl[e].r, tbl[e].op, tbl[e].a, tbl[e].b);
      rsp_ready = 2'b11;
      #1;
      chk("vec_req_ready", req_ready, 2'b01 << tbl[e].r);
      cyc();
      req_valid = 2'b00;
      #1;
      chk("vec_alu_porta", alu_porta, tbl[e].a);
      chk("vec_alu_portb", alu_portb, tbl[e].b);
      chk("vec_alu_aluop", alu_aluop, tbl[e].op);
      chk("vec_exec_ready", {busy, req_ready, rsp_valid}, 5'b10000);
      cyc();
      chk("vec_rsp_valid", rsp_valid, 2'b01 << tbl[e].r);
      chk("vec_rsp", {rsp_data, rsp_neg, rsp_zero, rsp_overflow},
          {tbl[e].d, tbl[e].neg, tbl[e].zero, tbl[e].ovf});
      chk("vec_rsp_alu_idle", alu_porta, 32'd0);
      cyc();
      chk("vec_back_idle", {busy, rsp_valid}, 3'b000);
    end

    // Contention: both requesters valid continuously after reset
    clear_inputs();
    do_reset();
    req_valid = 2'b11;
    set_req(0, ALU_SUB, 32'd9, 32'd9);
    set_req(1, ALU_SUB, 32'd9, 32'd9);
    rsp_ready = 2'b11;
    g = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_grant", req_ready, 2'b01 << g);
      cyc();
      cyc();
      chk("cont_rsp_owner", rsp_valid, 2'b01 << g);
      chk("cont_rsp", {rsp_data, rsp_neg, rsp_zero, rsp_overflow}, {32'd0, 1'b0, 1'b1, 1'b0});
      cyc();
      g = 1 - g;
    end

    // Back-pressure: owner 0 stalls 5 RESP cycles while requester 1 waits
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    rsp_ready = 2'b00;
    #1;
    chk("bp_grant", req_ready, 2'b01);
    cyc();
    req_valid = 2'b11;
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    #1;
    chk("bp_exec_ready", req_ready, 2'b00);
    for (int k = 0; k < 5; k++) begin
      cyc();
      rsp_ready = 2'b10;
      #1;
      chk("bp_hold_valid", rsp_valid, 2'b01);
      chk("bp_hold_rsp", {rsp_data, rsp_neg, rsp_zero, rsp_overflow}, {32'd7, 1'b0, 1'b0, 1'b0});
      chk("bp_hold_ready", {busy, req_ready}, 3'b100);
    end
    cyc();
    rsp_ready = 2'b01;
    #1;
    chk("bp_release_valid", rsp_valid, 2'b01);
    cyc();
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_next_grant", req_ready, 2'b10);
    req_valid = 2'b00;
    #1;
    cyc();

    // Reset during EXEC aborts the op and restores prio to requester 0
    req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    rsp_ready = 2'b11;
    #1;
    cyc();
    req_valid = 2'b00;
    RST = 1'b1;
    #1;
    chk("rst_in_exec", busy, 1'b1);
    cyc();
    RST = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp", {rsp_data, rsp_neg, rsp_zero, rsp_overflow}, 35'd0);
    req_valid = 2'b11;
    #1;
    chk("rst_prio", req_ready, 2'b01);
    req_valid = 2'b00;
    #1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_no_rsp", {busy, rsp_valid}, 3'b000);
    end

    // Randomized traffic against a cycle-level transaction model
    clear_inputs();
    do_reset();
    have_op = 1'b0;
    age     = 0;
    m_owner = 0;
    m_prio  = 0;
    m_op    = ALU_ADD;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
    for (int c = 0; c < 1500; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        req_aluop[i] = aluop_t'($urandom_range(0, 7));
        req_porta[i] = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
        req_portb[i] = ($urandom_range(0, 3) == 0) ? req_porta[i] : $urandom;
      end
      #1;
      w = 0;
      exp_ready = 2'b00;
      if (!have_op && req_valid != 2'b00) begin
        if (req_valid == 2'b11) w = m_prio;
        else                    w = (req_valid == 2'b10) ? 1 : 0;
        exp_ready = 2'b01 << w;
      end
      exp_rv = (have_op && age >= 2) ? (2'b01 << m_owner) : 2'b00;
      chk("rnd_req_ready", req_ready, exp_ready);
      chk("rnd_busy", busy, have_op);
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00)
        chk("rnd_rsp", {rsp_data, rsp_neg, rsp_zero, rsp_overflow}, m_res);
      if (have_op && age == 1)
        chk("rnd_alu", {alu_aluop, alu_porta, alu_portb}, {m_op, m_a, m_b});
      else
        chk("rnd_alu_zero", {alu_aluop, alu_porta, alu_portb}, 68'd0);

      if (!have_op && req_valid != 2'b00) begin
        have_op = 1'b1;
        age     = 1;
        m_owner = w;
        m_op    = req_aluop[w];
        m_a     = req_porta[w];
        m_b     = req_portb[w];
        m_res   = alu_fn(m_op, m_a, m_b);
        m_prio  = 1 - w;
      end else if (have_op) begin
        if (age >= 2 && rsp_ready[m_owner]) have_op = 1'b0;
        else if (age < 2)                   age++;
      end
      cyc();
    end

`ifdef ALU_ARB_PERF_EN
    clear_inputs();
    do_reset();
    chk("perf_reset", {grant_cnt0, grant_cnt1}, 64'd0);
    one_op(0);
    one_op(1);
    one_op(0);
    one_op(1);
    one_op(0);
    chk("perf_cnt0", grant_cnt0, 32'd3);
    chk("perf_cnt1", grant_cnt1, 32'd2);
    dut.grant_cnt0_q = 32'hFFFF_FFFF;
    one_op(0);
    chk("perf_wrap", grant_cnt0, 32'd0);
    chk("perf_cnt1_hold", grant_cnt1, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the single shared ALU in the execute datapath. It accepts operation requests (aluop, two operands) from two clients, for example the execute stage and a branch/address helper, or two harts. It grants them round-robin, drives the ALU for exactly one cycle per operation, captures the result and flags, and returns them to the owning requester through a valid/ready response. One operation is in flight at a time.

## Interface
Parameters:
- NREQ, 2: number of requesters; fixed at 2 in this revision.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_aluop  in  2×aluop_t  requested operation.
- req_porta, req_portb  in  2×32  operands.
- alu_aluop  out  aluop_t  to ALU.
- alu_porta, alu_portb  out  32  to ALU.
- alu_portout  in  32  ALU result (combinational in the same cycle).
- alu_neg, alu_zero, alu_overflow  in  1  ALU flags.
- rsp_valid  out  2  per-requester response valid; at most one bit high.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  32  captured result.
- rsp_neg, rsp_zero, rsp_overflow  out  1  captured flags.
- busy  out  1  high in any state other than IDLE.
- grant_cnt0, grant_cnt1  out  32  accepted-request counters; present only with ALU_ARB_PERF_EN.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - Arbitrate among the req_valid bits. If only one is set, that requester wins.
  - If both are set, the winner is the requester named by the priority pointer `prio`.
  - req_ready[winner] = 1, combinational from req_valid. Ready depends on valid; valid must not depend on ready.
  - On handshake, latch owner, aluop, porta and portb into the op register. Set `prio` to the non-winner. Go to EXEC.
- **EXEC:**
  - Drive alu_* from the op register.
  - Capture alu_portout and the three flags into the response register. Go to RESP.
- **RESP:**
  - rsp_valid[owner] = 1. Data and flags are held stable until handshake.
  - When rsp_ready[owner] = 1, go to IDLE.
  - rsp_ready of the non-owner is ignored. No requests are accepted in RESP or EXEC.
- Outside EXEC, alu_aluop, alu_porta and alu_portb are driven to 0.
- Operands and results pass through unmodified: no sign extension, no width change. Flags are the ALU's own flags, registered.
- A requester holding req_valid while not granted keeps its request pending. The arbiter does not require its inputs to stay stable until the handshake.

## Timing
- Latency: request handshake in cycle N, ALU driven in cycle N+1, rsp_valid high from cycle N+2.
- Peak throughput: one operation per 3 cycles when rsp_ready is held high.
- Reset values:
  - state = IDLE, prio = requester 0.
  - req_ready = 0 when no request is present; rsp_valid = 0; busy = 0.
  - rsp_data and all flags = 0; alu_* = 0.
  - Counters = 0.
- RST asserted in any state: the next edge returns to IDLE and aborts the in-flight op. No response is issued for it.
- Simultaneous requests: at most one grant; the other requester is guaranteed the next grant.
- Back-pressure: an rsp_ready stall of any length holds RESP and its outputs unchanged.

## Configuration
- Macro: ALU_ARB_PERF_EN.
- **Defined:**
  - grant_cnt0 and grant_cnt1 count request handshakes per requester.
  - Each counter increments by 1 in the handshake cycle.
  - Counters wrap from 0xFFFFFFFF to 0, and clear on RST.
- **Undefined:** the ports and counter registers do not exist. All other behaviour is identical.

## Structure
- cpu_types_pkg supplies aluop_t and word_t, which are reused as-is.
- New in cpu_types_pkg:
  - typedef alu_arb_state_t enum {IDLE, EXEC, RESP}.
  - typedef of the op-register struct (owner, aluop, porta, portb).
- One sub-module: rr_arb2, a 2-way round-robin grant. Its inputs are req[1:0], prio and an enable; its outputs are a one-hot grant. It is purely combinational; `prio` lives in alu_arbiter.

## Test plan
- Single request: requester 0 sends ALU_ADD, 5, 7, with rsp_ready = 1.
  - req_ready[0] is high in cycle 0; alu_porta = 5 in cycle 1.
  - rsp_valid[0] with rsp_data = 12 and zero/neg/overflow = 0 in cycle 2; IDLE in cycle 3.
- Flags: requester 1 sends ALU_ADD, 0x7FFFFFFF, 1.
  - Response rsp_data = 0x80000000, rsp_neg = 1, rsp_overflow = 1, rsp_valid[1] only.
- Contention: both requesters valid continuously after reset, each sending ALU_SUB, 9, 9.
  - Grants alternate 0, 1, 0, 1; every response is rsp_data = 0 with rsp_zero = 1.
- Back-pressure: rsp_ready[0] is held low 5 cycles in RESP.
  - rsp_valid[0], rsp_data and the flags stay constant; req_ready stays 0 throughout.
  - Handshake on cycle 6 returns the FSM to IDLE.
- Reset mid-op: RST asserted during EXEC.
  - The next cycle shows IDLE, busy = 0, rsp_valid = 0 and prio = 0.
- ALU_ARB_PERF_EN: after 3 grants to requester 0 and 2 to requester 1, grant_cnt0 = 3 and grant_cnt1 = 2.
  - With the counter preloaded to 0xFFFFFFFF, the next grant wraps it to 0.
